// File: rtl/pci_target_responder_if.sv
// PCI-style target bus bundle: initiator-driven frame/irdy/ad/cbe plus the
// target's registered responses. The AD tristate is split into ad_in,
// ad_out and ad_oe so the pad lives at the top level.
// Optional macro PCI_TGT_STOP_EN adds the active-low stop_n response.
// Modports: master = initiator view, slave = target view.
interface pci_target_responder_if;
  logic        frame_n;
  logic        irdy_n;
  logic [31:0] ad_in;
  logic [3:0]  cbe;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        trdy_n;
  logic        devsel_n;
`ifdef PCI_TGT_STOP_EN
  logic        stop_n;
`endif

  modport master (
    output frame_n, irdy_n, ad_in, cbe,
`ifdef PCI_TGT_STOP_EN
    input  stop_n,
`endif
    input  ad_out, ad_oe, trdy_n, devsel_n
  );

  modport slave (
    input  frame_n, irdy_n, ad_in, cbe,
`ifdef PCI_TGT_STOP_EN
    output stop_n,
`endif
    output ad_out, ad_oe, trdy_n, devsel_n
  );
endinterface

// File: rtl/pci_target_responder.sv
// PCI-style target: decodes an address phase against its window
// [BASE_ADDR, BASE_ADDR + 4*DEPTH) and serves single or burst reads/writes
// to a DEPTH-word local memory with byte enables. All bus outputs registered.
// Ports:
//   clk  - bus clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - pci_target_responder_if.slave (frame_n, irdy_n, ad_in, cbe in;
//          ad_out, ad_oe, trdy_n, devsel_n [, stop_n] out)
// Optional macro PCI_TGT_STOP_EN: disconnect-with-data (stop_n) at the last
// word instead of silently saturating the burst pointer.
module pci_target_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned DEPTH     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  pci_target_responder_if.slave   bus
);

  localparam int unsigned    PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [32:0]    WIN_LO  = {1'b0, BASE_ADDR};
  localparam logic [32:0]    WIN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [3:0]     CMD_RD  = 4'b0000;
  localparam logic [3:0]     CMD_WR  = 4'b0001;

  typedef enum logic [1:0] {IDLE, RD_TA, RD_DATA, WR_DATA} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic             bus_busy;
  logic [31:0]      mem [DEPTH];

  logic             hit_c;
  logic [PTR_W-1:0] addr_ptr_c;
  logic [PTR_W-1:0] ptr_inc_c;
  logic             xfer_c;
  logic             abort_c;

  // Address decode and transfer qualifiers
  always_comb begin
    hit_c      = ({1'b0, bus.ad_in} >= WIN_LO) && ({1'b0, bus.ad_in} < WIN_END) &&
                 ((bus.cbe == CMD_RD) || (bus.cbe == CMD_WR));
    // Borrows only travel upward, so the low slice of the offset is exact.
    addr_ptr_c = PTR_W'((bus.ad_in[PTR_W+1:0] - BASE_ADDR[PTR_W+1:0]) >> 2);
    ptr_inc_c  = (ptr == LAST) ? ptr : ptr + PTR_W'(1);
    xfer_c     = ((state == RD_DATA) || (state == WR_DATA)) && !bus.irdy_n && !bus.trdy_n;
    abort_c    = bus.frame_n && bus.irdy_n;
  end

  // Target state machine, memory and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      bus_busy     <= 1'b0;
      bus.trdy_n   <= 1'b1;
      bus.devsel_n <= 1'b1;
      bus.ad_oe    <= 1'b0;
      bus.ad_out   <= '0;
`ifdef PCI_TGT_STOP_EN
      bus.stop_n   <= 1'b1;
`endif
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // After a miss, ignore the bus until it returns to idle.
          if (bus_busy) begin
            if (abort_c) bus_busy <= 1'b0;
          end else if (!bus.frame_n) begin
            if (hit_c) begin
              ptr          <= addr_ptr_c;
              bus.devsel_n <= 1'b0;
              if (bus.cbe == CMD_WR) begin
                state      <= WR_DATA;
                bus.trdy_n <= 1'b0;
`ifdef PCI_TGT_STOP_EN
                bus.stop_n <= (addr_ptr_c != LAST);
`endif
              end else begin
                state <= RD_TA;
              end
            end else begin
              bus_busy <= 1'b1;
            end
          end
        end

        RD_TA: begin
          if (abort_c) begin
            state        <= IDLE;
            bus.devsel_n <= 1'b1;
          end else begin
            state      <= RD_DATA;
            bus.ad_oe  <= 1'b1;
            bus.ad_out <= mem[ptr];
            bus.trdy_n <= 1'b0;
`ifdef PCI_TGT_STOP_EN
            bus.stop_n <= (ptr != LAST);
`endif
          end
        end

        RD_DATA, WR_DATA: begin
          if (abort_c) begin
            state        <= IDLE;
            bus.trdy_n   <= 1'b1;
            bus.devsel_n <= 1'b1;
            bus.ad_oe    <= 1'b0;
`ifdef PCI_TGT_STOP_EN
            bus.stop_n   <= 1'b1;
`endif
          end else if (xfer_c) begin
            if (state == WR_DATA) begin
              for (int b = 0; b < 4; b++)
                if (bus.cbe[b]) mem[ptr][8*b +: 8] <= bus.ad_in[8*b +: 8];
            end
            if (bus.frame_n) begin
              state        <= IDLE;
              bus.trdy_n   <= 1'b1;
              bus.devsel_n <= 1'b1;
              bus.ad_oe    <= 1'b0;
`ifdef PCI_TGT_STOP_EN
              bus.stop_n   <= 1'b1;
`endif
            end else begin
`ifdef PCI_TGT_STOP_EN
              // Disconnected with data: keep stop_n low, refuse further phases.
              if (ptr == LAST) begin
                bus.trdy_n <= 1'b1;
              end else begin
                ptr        <= ptr_inc_c;
                bus.stop_n <= (ptr_inc_c != LAST);
                if (state == RD_DATA) bus.ad_out <= mem[ptr_inc_c];
              end
`else
              ptr <= ptr_inc_c;
              if (state == RD_DATA) bus.ad_out <= mem[ptr_inc_c];
`endif
            end
`ifdef PCI_TGT_STOP_EN
          end else if (bus.trdy_n && bus.frame_n) begin
            // Initiator released frame after a disconnect.
            state        <= IDLE;
            bus.devsel_n <= 1'b1;
            bus.ad_oe    <= 1'b0;
            bus.stop_n   <= 1'b1;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pci_target_responder.sv
// Randomized scoreboard bench for pci_target_responder. Works with or
// without PCI_TGT_STOP_EN defined.
module tb_pci_target_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pci_target_responder_if bus ();

  pci_target_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  logic [31:0] wq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {29'd0, bus.devsel_n, bus.trdy_n, bus.ad_oe}, 32'd6);
`ifdef PCI_TGT_STOP_EN
    check({name, "_stop"}, {31'd0, bus.stop_n}, 32'd1);
`endif
  endtask

  // Read-data monitor: whenever the target presents read data, compare to the
  // head of the scoreboard; pop only when the initiator completes the phase.
  always @(negedge clk) begin
    if (!rst && bus.ad_oe && !bus.trdy_n) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", bus.ad_out, 32'hxxxx_xxxx);
      end else begin
        check("rd_data", bus.ad_out, exp_q[0]);
        if (!bus.irdy_n) void'(exp_q.pop_front());
      end
    end
  end

  // One initiator transaction. wait_at: phase preceded by one irdy_n-high
  // cycle (>0). rst_at: phase at which reset is asserted instead (-1 none).
  task automatic xact(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                      input int wait_at, input int rst_at, input logic [3:0] be);
    bit is_rd, hit, stopped, bad, last_frame;
    int start, idx, n_eff, cyc;
    is_rd = (cmd == 4'b0000);
    hit   = ((cmd == 4'b0000) || (cmd == 4'b0001)) &&
            ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < {1'b0, BASE} + 33'(4 * DEPTH));
    start = hit ? int'((addr - BASE) >> 2) : 0;
    n_eff = n;
`ifdef PCI_TGT_STOP_EN
    if (hit && n > DEPTH - start) n_eff = DEPTH - start;
`endif
    if (hit && is_rd)
      for (int i = 0; i < n_eff; i++)
        exp_q.push_back(model_mem[(start + i > DEPTH - 1) ? DEPTH - 1 : start + i]);

    @(posedge clk); #1;
    bus.frame_n = 1'b0; bus.irdy_n = 1'b1; bus.ad_in = addr; bus.cbe = cmd;
    @(posedge clk); #1;

    if (!hit) begin
      bad = 1'b0;
      for (int i = 0; i < n; i++) begin
        bus.irdy_n = 1'b0; bus.frame_n = (i == n - 1); bus.ad_in = $urandom; bus.cbe = be;
        @(negedge clk);
        if (!bus.devsel_n || !bus.trdy_n || bus.ad_oe) bad = 1'b1;
        @(posedge clk); #1;
      end
      bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
      @(negedge clk);
      if (!bus.devsel_n || !bus.trdy_n || bus.ad_oe) bad = 1'b1;
      check("miss_quiet", {31'd0, bad}, 32'd0);
      return;
    end

    idx = start; stopped = 1'b0; last_frame = 1'b0;
    for (int i = 0; i < n_eff && !stopped; i++) begin
      if (i == wait_at && i > 0) begin
        bus.irdy_n = 1'b1; bus.frame_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
      end
      if (i == rst_at) begin
        rst = 1'b1; bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_mid_idle");
        check("rst_mid_adout", bus.ad_out, 32'd0);
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
        exp_q.delete();
        return;
      end
      bus.irdy_n = 1'b0;
      bus.frame_n = (i == n - 1);
      last_frame = (i == n - 1);
      bus.cbe = is_rd ? 4'hF : be;
      bus.ad_in = is_rd ? $urandom : wq[i];
      cyc = 1;
      forever begin
        @(negedge clk);
        if (!bus.trdy_n || cyc > 8) break;
        @(posedge clk); #1;
        cyc++;
      end
      if (cyc > 8) begin
        check("trdy_timeout", 32'd1, 32'd0);
        bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      if (i == 0) check("latency_devsel", {cyc[30:0], bus.devsel_n}, {31'(is_rd ? 2 : 1), 1'b0});
`ifdef PCI_TGT_STOP_EN
      check("stop_at_xfer", {31'd0, bus.stop_n}, {31'd0, idx != DEPTH - 1});
`endif
      if (!is_rd)
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[idx][8*b +: 8] = wq[i][8*b +: 8];
      @(posedge clk); #1;
`ifdef PCI_TGT_STOP_EN
      if (idx == DEPTH - 1) stopped = 1'b1;
`endif
      idx = (idx + 1 > DEPTH - 1) ? DEPTH - 1 : idx + 1;
    end

    if (stopped && !last_frame) begin
      bus.irdy_n = 1'b1; bus.frame_n = 1'b0;
      @(negedge clk);
`ifdef PCI_TGT_STOP_EN
      check("stop_hold", {30'd0, bus.stop_n, bus.trdy_n}, 32'd1);
`endif
      @(posedge clk); #1;
    end
    bus.frame_n = 1'b1; bus.irdy_n = 1'b1;
    @(negedge clk);
    check_idle("end_idle");
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic read_all();
    xact(BASE, 4'b0000, DEPTH, -1, -1, 4'hF);
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  cmd;
    int          n, st, kind;

    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    rst = 1'b1; bus.frame_n = 1'b1; bus.irdy_n = 1'b1; bus.ad_in = '0; bus.cbe = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_idle");
    check("reset_adout", bus.ad_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single full-word write and readback
    wq = '{32'hDEAD_BEEF};
    xact(32'h1000, 4'b0001, 1, -1, -1, 4'hF);
    xact(32'h1000, 4'b0000, 1, -1, -1, 4'hF);

    // Byte-enable merge at word 2
    wq = '{32'hAABB_CCDD};
    xact(32'h1008, 4'b0001, 1, -1, -1, 4'hF);
    wq = '{32'h1122_3344};
    xact(32'h1008, 4'b0001, 1, -1, -1, 4'b0101);
    check("be_merge_model", model_mem[2], 32'hAA22_CC44);
    xact(32'h1008, 4'b0000, 1, -1, -1, 4'hF);

    // Preload words 1..3 then burst read with one initiator wait mid-burst
    wq = '{32'h11, 32'h22, 32'h33};
    xact(32'h1004, 4'b0001, 3, -1, -1, 4'hF);
    xact(32'h1004, 4'b0000, 3, 1, -1, 4'hF);

    // Misses: out of window read/write, invalid command in window
    xact(32'h2000, 4'b0000, 2, -1, -1, 4'hF);
    wq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    xact(32'h2000, 4'b0001, 2, -1, -1, 4'hF);
    xact(32'h1000, 4'b0110, 2, -1, -1, 4'hF);
    read_all();

    // 12-word burst write across the end of the window
    wq.delete();
    for (int i = 1; i <= 12; i++) wq.push_back(32'(i));
    xact(32'h1000, 4'b0001, 12, -1, -1, 4'hF);
    read_all();

    // Reset during the second phase of a burst read, then normal traffic
    xact(32'h1000, 4'b0000, 4, -1, 1, 4'hF);
    read_all();
    wq = '{32'hCAFE_F00D, 32'h0BAD_F00D};
    xact(32'h1010, 4'b0001, 2, -1, -1, 4'hF);
    xact(32'h1010, 4'b0000, 2, -1, -1, 4'hF);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      st   = $urandom_range(0, DEPTH - 1);
      addr = BASE + 32'(4 * st) + 32'($urandom_range(0, 3));
      cmd  = 4'($urandom_range(0, 1));
      if (kind == 0) addr = ($urandom_range(0, 1) == 1) ? BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255))
                                                          : BASE - 32'd4;
      if (kind == 1) cmd = 4'($urandom_range(2, 15));
      n = $urandom_range(1, 5);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      xact(addr, cmd, n, $urandom_range(0, n), -1, 4'($urandom_range(0, 15)));
    end
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_target_responder.md
Name: pci_target_responder

Overview:
- PCI-style target (responder) for the shared-bus device subsystem. It answers transactions started by an initiator on the frame/irdy/ad/cbe bus.
- Decodes the address phase against its own window, asserts devsel/trdy, and completes single or burst read/write data phases against a DEPTH-word local memory with byte enables.
- All bus outputs are registered. The tristate is split into in/out/oe so the top level owns the pad.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of word 0 of the target window.
- DEPTH, 10, number of 32-bit memory words. Window is BASE_ADDR .. BASE_ADDR+4*DEPTH-1.

Ports:
- clk  input  1  bus clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- frame_n  input  1  active-low FRAME from the bus.
- irdy_n  input  1  active-low IRDY from the initiator.
- ad_in  input  32  AD bus, sampled value.
- cbe  input  4  command in the address phase; byte enables in data phases (bit=1 means byte enabled).
- ad_out  output  32  read data driven onto AD.
- ad_oe  output  1  1 = target drives AD.
- trdy_n  output  1  active-low TRDY.
- devsel_n  output  1  active-low DEVSEL.

Behaviour:
- Commands: 4'b0000 = read, 4'b0001 = write. Any other command is ignored (no devsel).
- Reset values: trdy_n=1, devsel_n=1, ad_oe=0, ad_out=0, state=IDLE, ptr=0, all memory words=0. Reset mid-transaction forces these values at that edge. The aborted transaction is not resumed.
- States: IDLE, RD_TA, RD_DATA, WR_DATA.
- IDLE:
  - Address phase is an edge where frame_n=0 while in IDLE.
  - Hit = ad_in inside the window and cmd valid. On hit, ptr = (ad_in-BASE_ADDR)>>2; ad_in[1:0] are ignored.
  - Miss: stay in IDLE and drive nothing until frame_n=1 and irdy_n=1 are both seen.
- Write hit: go to WR_DATA. After the address edge, devsel_n=0 and trdy_n=0 (zero wait states).
- Read hit:
  - Go to RD_TA (turnaround). After the address edge, devsel_n=0, trdy_n=1, ad_oe=0.
  - Next edge: go to RD_DATA with ad_oe=1, ad_out=mem[ptr], trdy_n=0. Read latency is 2 clocks from the address edge to trdy_n=0.
- Data transfer: an edge in a data state with irdy_n=0 and trdy_n=0.
  - Write: for each i, mem[ptr][8i+7:8i] = ad_in[8i+7:8i] if cbe[i]=1; disabled bytes keep their old value.
  - Read: ad_out updates to mem[ptr+1] after the edge.
- Wait states:
  - irdy_n=1 in a data state: no transfer, all outputs held.
  - Target never inserts waits after the first data phase.
- Pointer advance: ptr increments on every transfer. At ptr=DEPTH-1 it saturates; further writes overwrite the last word and reads repeat it. Without STOP this is silent.
- Last phase: a transfer with frame_n=1 ends the transaction. After that edge: IDLE, trdy_n=1, devsel_n=1, ad_oe=0.
- Initiator abort: frame_n=1 and irdy_n=1 in any non-IDLE state returns to IDLE with idle outputs, no transfer.
- Back-to-back: a new address phase is accepted on the first IDLE edge after the previous transaction ends.
- Memory has no other access path; it is visible only through bus reads.

Optional Feature:
- Macro: PCI_TGT_STOP_EN.
- When defined:
  - Adds output stop_n (1 bit, reset 1).
  - When the transfer that targets word DEPTH-1 is presented, stop_n=0 together with trdy_n=0 (disconnect with data).
  - stop_n stays 0 with trdy_n=1 until frame_n=1 is sampled, then returns to idle values. No writes or transfers past DEPTH-1.
- When undefined: no stop_n port; saturation rule above applies.

Test Plan:
- Single write 0x1000, cmd 0001, data 0xDEADBEEF, cbe 1111, frame_n high with irdy_n low on the data phase -> devsel_n/trdy_n low for exactly 1 clock; readback gives 0xDEADBEEF.
- Write 0xAABBCCDD to 0x1008, then write 0x11223344 with cbe 0101 -> readback 0xAA22CC44.
- Preload words 1..3 with 0x11, 0x22, 0x33; burst read of 3 from 0x1004 with irdy_n high for one cycle mid-burst -> trdy_n low 2 clocks after the address edge; ad_out = 0x11, 0x22 (held during wait), 0x33; then ad_oe=0 and devsel_n=1.
- Address 0x2000 (miss) read and write, and 0x1000 with cmd 0110 -> devsel_n, trdy_n, ad_oe stay inactive for the whole transaction; memory unchanged.
- Burst write of 12 words (values 1..12) from 0x1000:
  - Macro undefined: mem[9]=12, mem[0..8]=1..9.
  - Macro defined: stop_n=0 on the 10th phase, mem[9]=10, values 11 and 12 never written.
- Assert rst during the 2nd phase of a burst read -> outputs idle at that edge, ptr=0, memory words read back 0 on a following read. The next transaction completes normally.
